// File: rtl/jpeg_block_pkg.sv
// rtl/jpeg_block_pkg.sv - shared 8x8 block constants, occupancy type and zigzag lookup
package jpeg_block_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int DEPTH      = 64;
    localparam int BLOCK_BITS = DATA_WIDTH * DEPTH;

    // Number of complete blocks resident in the ping-pong storage.
    typedef enum logic [1:0] {
        HELD_NONE = 2'd0,
        HELD_ONE  = 2'd1,
        HELD_TWO  = 2'd2
    } held_t;

    // Maps output sequence number to natural (raster) coefficient index.
    function automatic logic [5:0] zigzag_addr(input logic [5:0] seq);
        logic [5:0] addr;
        case (seq)
            6'd0:  addr = 6'd0;   6'd1:  addr = 6'd1;   6'd2:  addr = 6'd8;   6'd3:  addr = 6'd16;
            6'd4:  addr = 6'd9;   6'd5:  addr = 6'd2;   6'd6:  addr = 6'd3;   6'd7:  addr = 6'd10;
            6'd8:  addr = 6'd17;  6'd9:  addr = 6'd24;  6'd10: addr = 6'd32;  6'd11: addr = 6'd25;
            6'd12: addr = 6'd18;  6'd13: addr = 6'd11;  6'd14: addr = 6'd4;   6'd15: addr = 6'd5;
            6'd16: addr = 6'd12;  6'd17: addr = 6'd19;  6'd18: addr = 6'd26;  6'd19: addr = 6'd33;
            6'd20: addr = 6'd40;  6'd21: addr = 6'd48;  6'd22: addr = 6'd41;  6'd23: addr = 6'd34;
            6'd24: addr = 6'd27;  6'd25: addr = 6'd20;  6'd26: addr = 6'd13;  6'd27: addr = 6'd6;
            6'd28: addr = 6'd7;   6'd29: addr = 6'd14;  6'd30: addr = 6'd21;  6'd31: addr = 6'd28;
            6'd32: addr = 6'd35;  6'd33: addr = 6'd42;  6'd34: addr = 6'd49;  6'd35: addr = 6'd56;
            6'd36: addr = 6'd57;  6'd37: addr = 6'd50;  6'd38: addr = 6'd43;  6'd39: addr = 6'd36;
            6'd40: addr = 6'd29;  6'd41: addr = 6'd22;  6'd42: addr = 6'd15;  6'd43: addr = 6'd23;
            6'd44: addr = 6'd30;  6'd45: addr = 6'd37;  6'd46: addr = 6'd44;  6'd47: addr = 6'd51;
            6'd48: addr = 6'd58;  6'd49: addr = 6'd59;  6'd50: addr = 6'd52;  6'd51: addr = 6'd45;
            6'd52: addr = 6'd38;  6'd53: addr = 6'd31;  6'd54: addr = 6'd39;  6'd55: addr = 6'd46;
            6'd56: addr = 6'd53;  6'd57: addr = 6'd60;  6'd58: addr = 6'd61;  6'd59: addr = 6'd54;
            6'd60: addr = 6'd47;  6'd61: addr = 6'd55;  6'd62: addr = 6'd62;  6'd63: addr = 6'd63;
            default: addr = 6'd0;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/zigzag_index_rom.sv
// rtl/zigzag_index_rom.sv - sequence number to storage address, zigzag or pass-through
import jpeg_block_pkg::*;

module zigzag_index_rom #(
    parameter int ZIGZAG = 1
) (
    input  logic [5:0] seq,
    output logic [5:0] addr
);

    // Table lookup when zigzag ordering is selected, otherwise raster order.
    always_comb begin
        addr = (ZIGZAG != 0) ? zigzag_addr(seq) : seq;
    end

endmodule

// File: rtl/block_serializer_64x12bit.sv
// rtl/block_serializer_64x12bit.sv - ping-pong 8x8 block buffer streaming one coefficient per cycle
import jpeg_block_pkg::*;

module block_serializer_64x12bit #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 64,
    parameter int ZIGZAG     = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH*DEPTH-1:0]   in_block,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [5:0]                    out_index,
    output logic                          out_last
);

    logic [DATA_WIDTH-1:0] bank_mem [2][DEPTH];

    held_t      held;
    held_t      held_next;
    logic       rd_bank;
    logic       rd_bank_next;
    logic [5:0] rd_cnt;
    logic [5:0] rd_cnt_next;

    logic       accept;
    logic       xfer;
    logic       last_xfer;
    logic       wr_bank;
    logic [5:0] rd_addr;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (held != HELD_TWO);
    assign out_valid = (held != HELD_NONE);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (rd_cnt == 6'd63);

    // An empty buffer loads straight into the bank about to be read; otherwise the idle bank.
    assign wr_bank = (held == HELD_NONE) ? rd_bank : ~rd_bank;

    zigzag_index_rom #(
        .ZIGZAG (ZIGZAG)
    ) u_zigzag_index_rom (
        .seq  (rd_cnt),
        .addr (rd_addr)
    );

    assign out_data  = out_valid ? bank_mem[rd_bank][rd_addr] : '0;
    assign out_index = rd_cnt;
    assign out_last  = out_valid && (rd_cnt == 6'd63);

    // Next occupancy, read bank and read counter from the two handshakes.
    always_comb begin
        held_next    = held;
        rd_bank_next = rd_bank;
        rd_cnt_next  = rd_cnt;
        if (xfer) begin
            rd_cnt_next = rd_cnt + 6'd1;
        end
        if (last_xfer) begin
            rd_bank_next = ~rd_bank;
        end
        case (held)
            HELD_NONE: begin
                if (accept) held_next = HELD_ONE;
            end
            HELD_ONE: begin
                if (accept && !last_xfer)      held_next = HELD_TWO;
                else if (!accept && last_xfer) held_next = HELD_NONE;
            end
            HELD_TWO: begin
                if (last_xfer) held_next = HELD_ONE;
            end
            default: held_next = HELD_NONE;
        endcase
    end

    // Occupancy and read-pointer state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held    <= HELD_NONE;
            rd_bank <= 1'b0;
            rd_cnt  <= 6'd0;
        end else begin
            held    <= held_next;
            rd_bank <= rd_bank_next;
            rd_cnt  <= rd_cnt_next;
        end
    end

    // Whole-block load into the selected bank; element 0 sits in the MSBs of in_block.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    bank_mem[b][k] <= '0;
                end
            end
        end else if (accept) begin
            for (int k = 0; k < DEPTH; k++) begin
                bank_mem[wr_bank][k] <= in_block[DATA_WIDTH*(DEPTH-k)-1 -: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_block_serializer_64x12bit.sv
// tb/tb_block_serializer_64x12bit.sv - scoreboard bench for natural and zigzag serializer instances
module tb_block_serializer_64x12bit;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [767:0] in_block;
    logic         out_ready;

    logic         in_ready_n, out_valid_n, out_last_n;
    logic [11:0]  out_data_n;
    logic [5:0]   out_index_n;
    logic         in_ready_z, out_valid_z, out_last_z;
    logic [11:0]  out_data_z;
    logic [5:0]   out_index_z;

    block_serializer_64x12bit #(.DATA_WIDTH(12), .DEPTH(64), .ZIGZAG(0)) dut_nat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_block(in_block), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_data(out_data_n), .out_index(out_index_n), .out_last(out_last_n));

    block_serializer_64x12bit #(.DATA_WIDTH(12), .DEPTH(64), .ZIGZAG(1)) dut_zz (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_z),
        .in_block(in_block), .out_valid(out_valid_z), .out_ready(out_ready),
        .out_data(out_data_z), .out_index(out_index_z), .out_last(out_last_z));

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] data;
        logic [5:0]  index;
        logic        last;
    } exp_t;

    typedef struct {
        int          seq;
        logic [11:0] nat;
        logic [11:0] zz;
    } vec_t;

    int zz_tab [64] = '{
        0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
       12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
       35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
       58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

    exp_t        q_nat[$];
    exp_t        q_zz[$];
    int          mheld;
    int          xfer_cnt;
    int          xfer_base;
    int          ready_mode;
    bit          watch_c;
    bit          cap_en;
    logic [11:0] cap_nat [64];
    logic [11:0] cap_zz  [64];
    int          n_checks;
    int          n_fail;
    vec_t        vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [767:0] mk_block(input int base, input bit desc);
        logic [767:0] b;
        int v;
        b = '0;
        for (int k = 0; k < 64; k++) begin
            v = desc ? (4095 - k) : (base + k);
            b[767-12*k -: 12] = v[11:0];
        end
        return b;
    endfunction

    // Downstream ready: always high, or a coin toss each cycle.
    always @(posedge clock) begin
        #1;
        out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset_n !== 1'b1) begin
            q_nat.delete();
            q_zz.delete();
            mheld = 0;
        end else begin
            chk("in_ready_nat", {31'd0, in_ready_n}, {31'd0, mheld != 2});
            chk("in_ready_zz", {31'd0, in_ready_z}, {31'd0, mheld != 2});
            chk("out_valid_nat", {31'd0, out_valid_n}, {31'd0, mheld != 0});
            chk("out_valid_zz", {31'd0, out_valid_z}, {31'd0, mheld != 0});
            if (!out_valid_n) begin
                chk("idle_data", {20'd0, out_data_n}, 0);
                chk("idle_last", {31'd0, out_last_n}, 0);
                chk("idle_index", {26'd0, out_index_n}, 0);
            end
            if (in_valid && in_ready_n) begin
                if (watch_c) chk("third_block_wait", xfer_cnt - xfer_base, 64);
                for (int s = 0; s < 64; s++) begin
                    exp_t e;
                    e.index = s[5:0];
                    e.last  = (s == 63);
                    e.data  = in_block[767-12*s -: 12];
                    q_nat.push_back(e);
                    e.data  = in_block[767-12*zz_tab[s] -: 12];
                    q_zz.push_back(e);
                end
                mheld++;
            end
            if (out_valid_n) begin
                if (q_nat.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t en, ez;
                    en = q_nat[0];
                    ez = q_zz[0];
                    chk("nat_data", {20'd0, out_data_n}, {20'd0, en.data});
                    chk("nat_index", {26'd0, out_index_n}, {26'd0, en.index});
                    chk("nat_last", {31'd0, out_last_n}, {31'd0, en.last});
                    chk("zz_data", {20'd0, out_data_z}, {20'd0, ez.data});
                    chk("zz_index", {26'd0, out_index_z}, {26'd0, ez.index});
                    chk("zz_last", {31'd0, out_last_z}, {31'd0, ez.last});
                    if (out_ready) begin
                        void'(q_nat.pop_front());
                        void'(q_zz.pop_front());
                        xfer_cnt++;
                        if (cap_en) begin
                            cap_nat[en.index] = out_data_n;
                            cap_zz[en.index]  = out_data_z;
                        end
                        if (en.last) mheld--;
                    end
                end
            end
        end
    end

    task automatic send_block(input logic [767:0] b);
        bit acc;
        bit r;
        acc = 1'b0;
        in_block = b;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clock);
            r = in_ready_n;
            @(posedge clock);
            #1;
            acc = r;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clock);
            #1;
            done = (out_valid_n == 1'b0) && (q_nat.size() == 0);
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_index(input int idx);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            hit = (out_valid_n == 1'b1) && (out_index_n == idx[5:0]);
            if (!hit) begin
                @(posedge clock);
                #1;
            end
        end
        if (!hit) chk("index_timeout", 0, 1);
    endtask

    initial begin
        vecs[0] = '{0, 12'd0, 12'd0};
        vecs[1] = '{2, 12'd2, 12'd8};
        vecs[2] = '{3, 12'd3, 12'd16};
        vecs[3] = '{10, 12'd10, 12'd32};
        vecs[4] = '{19, 12'd19, 12'd33};
        vecs[5] = '{20, 12'd20, 12'd40};
        vecs[6] = '{35, 12'd35, 12'd56};
        vecs[7] = '{61, 12'd61, 12'd55};
        vecs[8] = '{62, 12'd62, 12'd62};
        vecs[9] = '{63, 12'd63, 12'd63};

        n_checks = 0; n_fail = 0; xfer_cnt = 0; xfer_base = 0;
        reset_n = 1'b0; in_valid = 1'b0; in_block = '0;
        ready_mode = 0; watch_c = 1'b0; cap_en = 1'b0;
        for (int s = 0; s < 64; s++) begin
            cap_nat[s] = 12'hfff;
            cap_zz[s]  = 12'hfff;
        end

        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", {31'd0, in_ready_n}, 1);
        chk("rst_out_valid", {31'd0, out_valid_n}, 0);
        chk("rst_out_data", {20'd0, out_data_z}, 0);
        chk("rst_out_index", {26'd0, out_index_n}, 0);
        chk("rst_out_last", {31'd0, out_last_n}, 0);
        reset_n = 1'b1;

        // Single block k=k, both orders; first output the cycle after accept.
        cap_en = 1'b1;
        send_block(mk_block(0, 1'b0));
        chk("latency_valid", {31'd0, out_valid_n}, 1);
        chk("latency_data", {20'd0, out_data_n}, 0);
        wait_drain();
        cap_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("vec_nat", {20'd0, cap_nat[vecs[i].seq]}, {20'd0, vecs[i].nat});
            chk("vec_zz", {20'd0, cap_zz[vecs[i].seq]}, {20'd0, vecs[i].zz});
        end

        // Back-to-back blocks, third held off until block one's last pop.
        @(posedge clock); #1;
        xfer_base = xfer_cnt;
        send_block(mk_block(0, 1'b0));
        send_block(mk_block(100, 1'b0));
        chk("two_held_ready", {31'd0, in_ready_n}, 0);
        watch_c = 1'b1;
        send_block(mk_block(200, 1'b0));
        watch_c = 1'b0;
        wait_drain();

        // Random backpressure with descending values.
        ready_mode = 1;
        send_block(mk_block(0, 1'b1));
        wait_drain();
        ready_mode = 0;

        // Reset mid-stream discards the block.
        @(posedge clock); #1;
        send_block(mk_block(0, 1'b0));
        wait_index(20);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid_n}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("post_rst_valid", {31'd0, out_valid_n}, 0);
        chk("post_rst_index", {26'd0, out_index_n}, 0);
        @(posedge clock); #1;
        send_block(mk_block(0, 1'b0));
        chk("restart_index", {26'd0, out_index_n}, 0);
        chk("restart_data", {20'd0, out_data_z}, 0);
        wait_drain();

        // Accept on the same edge as the last pop with one block held.
        send_block(mk_block(0, 1'b0));
        wait_index(63);
        in_block = mk_block(300, 1'b0);
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("swap_valid", {31'd0, out_valid_n}, 1);
        chk("swap_ready", {31'd0, in_ready_n}, 1);
        chk("swap_index", {26'd0, out_index_n}, 0);
        chk("swap_data_nat", {20'd0, out_data_n}, 300);
        chk("swap_data_zz", {20'd0, out_data_z}, 300);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
